// File: rtl/elastic_credit_counter_dataless_pkg.sv
// Shared helpers for dataless credit and sharing blocks.
// credit_width(n): bits needed to hold a count of 0..n.
package elastic_credit_counter_dataless_pkg;

    function automatic int credit_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/elastic_credit_counter_dataless.sv
// Credit source for a dataless elastic channel: issues up to NUM_CREDITS
// tokens on outs and takes them back on ins.
// Ports: clk, rst (sync, high), ins_valid/ins_ready (credit return),
//   outs_valid/outs_ready (credit issue), count (current credits).
module elastic_credit_counter_dataless
    import elastic_credit_counter_dataless_pkg::*;
#(
    parameter int NUM_CREDITS = 4,
    parameter bit BYPASS      = 1'b0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  ins_valid,
    output logic                                  ins_ready,
    output logic                                  outs_valid,
    input  logic                                  outs_ready,
    output logic [credit_width(NUM_CREDITS)-1:0]  count
);

    localparam int CW = credit_width(NUM_CREDITS);
    localparam logic [CW-1:0] MAX = CW'(NUM_CREDITS);
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [CW-1:0] cnt;
    logic          full;
    logic          empty;
    logic          take;
    logic          give;

    assign full  = (cnt == MAX);
    assign empty = (cnt == '0);

    // With bypass, a returning credit can be reissued combinationally
    // while the store is empty.
    if (BYPASS) begin : g_bypass
        assign outs_valid = ~empty | ins_valid;
    end else begin : g_no_bypass
        assign outs_valid = ~empty;
    end

    // A full counter can still accept a return if one leaves this cycle.
    assign ins_ready = ~full | outs_ready;

    assign take  = outs_valid & outs_ready;
    assign give  = ins_valid & ins_ready;
    assign count = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= MAX;
        end else if (take & ~give) begin
            cnt <= cnt - ONE;
        end else if (give & ~take) begin
            cnt <= cnt + ONE;
        end
    end

    a_cnt_bound: assert property (
        @(posedge clk) disable iff (rst) cnt <= MAX);

    a_no_underflow: assert property (
        @(posedge clk) disable iff (rst) !(take && !give && empty));

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst) !(give && !take && full));

endmodule

// File: tb/tb_elastic_credit_counter_dataless.sv
// Randomised and directed bench for elastic_credit_counter_dataless,
// running a BYPASS=0 and a BYPASS=1 instance side by side.
module tb_elastic_credit_counter_dataless;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       ins_valid;
    logic       outs_ready;
    logic       ir0, ov0, ir1, ov1;
    logic [2:0] cnt0, cnt1;

    int checks   = 0;
    int failures = 0;
    int cr[2];
    int obs_take = 0;
    int obs_give = 0;

    always #5 clk = ~clk;

    elastic_credit_counter_dataless #(.NUM_CREDITS(N), .BYPASS(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .ins_valid(ins_valid), .ins_ready(ir0),
        .outs_valid(ov0), .outs_ready(outs_ready),
        .count(cnt0)
    );

    elastic_credit_counter_dataless #(.NUM_CREDITS(N), .BYPASS(1'b1)) dut1 (
        .clk(clk), .rst(rst),
        .ins_valid(ins_valid), .ins_ready(ir1),
        .outs_valid(ov1), .outs_ready(outs_ready),
        .count(cnt1)
    );

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
        end
    endtask

    // One clock cycle: drive, check against the token model, advance it.
    task automatic cyc(input logic r, input logic iv, input logic ordy);
        bit ov[2], ir[2], tk[2], gv[2];
        rst        = r;
        ins_valid  = iv;
        outs_ready = ordy;
        #2;
        for (int m = 0; m < 2; m++) begin
            ov[m] = (cr[m] > 0) || (m == 1 && iv);
            ir[m] = (cr[m] < N) || ordy;
            tk[m] = ov[m] && ordy;
            gv[m] = iv && ir[m];
        end
        check("count0", int'(cnt0), cr[0]);
        check("outs_valid0", int'(ov0), int'(ov[0]));
        check("ins_ready0", int'(ir0), int'(ir[0]));
        check("count1", int'(cnt1), cr[1]);
        check("outs_valid1", int'(ov1), int'(ov[1]));
        check("ins_ready1", int'(ir1), int'(ir[1]));
        if (!r) begin
            obs_take += int'(ov0 && ordy);
            obs_give += int'(iv && ir0);
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (r) cr[m] = N;
            else   cr[m] = cr[m] - int'(tk[m]) + int'(gv[m]);
        end
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        ins_valid  = 1'b0;
        outs_ready = 1'b0;
        @(posedge clk);
        #1;
        cr[0] = N;
        cr[1] = N;

        cyc(1'b1, 1'b0, 1'b0);
        check("reset_count", int'(cnt0), N);

        // drain
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b1);
        check("drained", int'(cnt0), 0);

        // refill
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0);
        check("refilled", int'(cnt0), N);

        // simultaneous take/give at count 2
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        obs_take = 0;
        obs_give = 0;
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b1);
        check("sim_takes", obs_take, 10);
        check("sim_gives", obs_give, 10);
        check("sim_count", int'(cnt0), 2);

        // back to full, then give+take at full, then drop outs_ready
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        check("full_hold", int'(cnt0), N);

        // empty: bypass vs no bypass
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        check("bypass_cnt1", int'(cnt1), 0);
        check("nobypass_cnt0", int'(cnt0), 1);

        // reset mid-operation with a pending take
        cyc(1'b1, 1'b0, 1'b1);
        check("rst_mid_cnt", int'(cnt0), N);
        check("rst_mid_ov", int'(ov0), 1);

        // random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) == 0),
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/elastic_credit_counter_dataless.md
Name: elastic_credit_counter_dataless

Overview:
- Credit source at the return end of a dataless elastic channel.
- Holds NUM_CREDITS tokens at reset, issues one per outs handshake, and takes one back per ins handshake.
- Sits in front of a bounded dataless FIFO or shared unit; guarantees no more than NUM_CREDITS tokens in flight downstream.
- Issued credits travel forward; consumed tokens return on the ins side.

Parameters:
- NUM_CREDITS, 4, initial and maximum credit count; legal range 1..1024.
- BYPASS, 0, 1 = a returning credit may be reissued in the same cycle when the count is 0 (combinational ins->outs path); 0 = the count must be nonzero for outs_valid.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- ins_valid  input  1  a credit is being returned.
- ins_ready  output  1  credit return accepted.
- outs_valid  output  1  a credit is available for issue.
- outs_ready  input  1  downstream takes a credit.
- count  output  CW  current credit count, for debug/verification; CW = $clog2(NUM_CREDITS+1).

Behaviour:
- State:
  - Register cnt[CW-1:0]. No other state.
  - Reset (rst high at a clock edge): cnt <= NUM_CREDITS.
  - rst overrides every concurrent handshake; handshakes in a reset cycle are dropped.
- Derived signals:
  - full = (cnt == NUM_CREDITS).
  - empty = (cnt == 0).
- Outputs, BYPASS=0:
  - outs_valid = ~empty.
  - ins_ready = ~full | outs_ready.
- Outputs, BYPASS=1:
  - outs_valid = ~empty | ins_valid.
  - ins_ready = ~full | outs_ready.
- Outputs after reset: outs_valid=1, ins_ready=outs_ready (counter is full), count=NUM_CREDITS.
- Handshakes:
  - take = outs_valid & outs_ready.
  - give = ins_valid & ins_ready.
- Counter update:
  - take & ~give: cnt <= cnt-1.
  - give & ~take: cnt <= cnt+1.
  - both or neither: cnt holds.
- Boundary conditions:
  - Full, give and take together: allowed; cnt stays NUM_CREDITS.
  - Full, give alone: impossible because ins_ready=0.
  - Empty, BYPASS=1, ins_valid & outs_ready: the credit passes through; give and take both fire; cnt stays 0.
  - Empty, BYPASS=0: outs_valid=0. A give raises cnt to 1, and outs_valid rises the next cycle (1-cycle return latency).
- Arithmetic:
  - cnt is unsigned; it never goes below 0 or above NUM_CREDITS.
  - Add a simulation-only assertion that flags either bound being violated.
- Protocol:
  - Valid never depends combinationally on ready of the same port.
  - Once asserted, outs_valid stays high until take. The counter only decreases on take, and a nonzero cnt keeps valid high.
  - With BYPASS=1, persistence of a bypassed valid relies on ins_valid persistence, which is guaranteed upstream.
- No latency on issue: a credit present in cnt is offered the same cycle.

Decomposition:
- Shared dataless support package holds the credit_width(n) function returning $clog2(n+1); it is reused by other credit and sharing blocks.
- No sub-module; a single always block for cnt plus continuous assigns.
- Downstream composition with elastic_fifo_inner_dataless (NUM_SLOTS = NUM_CREDITS) is done at the wrapper level, not inside this block.

Test Plan:
- Reset then drain, NUM_CREDITS=4, BYPASS=0, outs_ready=1, ins_valid=0 for 6 cycles:
  - outs_valid high for exactly 4 cycles, count steps 4,3,2,1,0.
  - outs_valid=0 afterwards.
- Refill from empty, ins_valid=1 for 4 cycles, outs_ready=0:
  - ins_ready=1 each cycle, count goes 1,2,3,4.
  - 5th cycle: ins_ready=0, count stays 4.
- Simultaneous events, count=2, ins_valid=1 and outs_ready=1 for 10 cycles: count stays 2; 10 takes and 10 gives observed.
- At full, count=4, ins_valid=1 and outs_ready=1 together:
  - ins_ready=1, count stays 4.
  - Drop outs_ready: ins_ready=0 the same cycle.
- Bypass, BYPASS=1, count=0, ins_valid=1, outs_ready=1:
  - outs_valid=1 in the same cycle, count stays 0.
  - With BYPASS=0, same stimulus: outs_valid=0, and count becomes 1 next cycle.
- Reset mid-operation: count=1 with a pending take, assert rst for 1 cycle → next cycle count=4 and outs_valid=1; the take in the reset cycle is not counted.
